mac_st_driver: RTL

- Sequencer that drives a sum-together MAC (mac_st and its top wrapper) from the producer side.
- Accepts a dot-product job (length, precision mode) and streams packed activation/weight pairs into the MAC.
- Issues the accumulator clear and waits out the MAC pipeline latency.
- Captures the accumulated z and returns it on a valid/ready result port. It is the initiator/consumer for the MAC's a/w/accu_rst/config_aw/z interface.

---
 rtl/mac_st_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mac_st_driver.sv
// ---------------------------------------------------------------------------
// mac_st_driver
//
// Producer-side sequencer for a sum-together MAC. It accepts one dot-product
// job at a time (length + precision mode), pulses the MAC accumulator clear,
// streams the operand pairs into the MAC unchanged, waits for the MAC
// pipeline to settle, then captures z and offers it on a valid/ready port.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cfg_valid/ready job request handshake; cfg_len pairs, cfg_mode
//                   (0 = 8x8, 1 = packed 4x4+4x4)
//   op_valid/ready  operand pair handshake; op_a activation, op_w weight
//   mac_a, mac_w    registered operand pair towards the MAC
//   mac_accu_rst    registered accumulator clear towards the MAC
//   mac_config_aw   registered precision mode towards the MAC
//   mac_z           accumulated value from the MAC
//   res_valid/ready result handshake; res_z captured sum, res_mode its mode
// ---------------------------------------------------------------------------
module mac_st_driver #(
  parameter int HEADROOM = 4,
  parameter int LEN_W    = 10,
  parameter int MAC_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_mode,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [7:0]            op_a,
  input  logic [7:0]            op_w,
  output logic [7:0]            mac_a,
  output logic [7:0]            mac_w,
  output logic                  mac_accu_rst,
  output logic                  mac_config_aw,
  input  logic [16+HEADROOM-1:0] mac_z,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [16+HEADROOM-1:0] res_z,
  output logic                  res_mode
);

  localparam int WAIT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;

  logic cfg_hs;
  logic op_hs;
  logic res_hs;

  assign cfg_hs = cfg_valid & cfg_ready;
  assign op_hs  = op_valid & op_ready;
  assign res_hs = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      wait_cnt      <= '0;
      cfg_ready     <= 1'b0;
      op_ready      <= 1'b0;
      mac_a         <= '0;
      mac_w         <= '0;
      mac_accu_rst  <= 1'b0;
      mac_config_aw <= 1'b0;
      res_valid     <= 1'b0;
      res_z         <= '0;
      res_mode      <= 1'b0;
    end else begin
      // Unless a pair is consumed this cycle the MAC sees a zero product,
      // so bubbles and the drain phase never disturb the running sum.
      mac_a        <= '0;
      mac_w        <= '0;
      mac_accu_rst <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_hs) begin
            remaining     <= cfg_len;
            mac_config_aw <= cfg_mode;
            res_mode      <= cfg_mode;
            cfg_ready     <= 1'b0;
            mac_accu_rst  <= 1'b1;
            state         <= CLEAR;
          end else begin
            // cfg_ready comes up one cycle after reset release.
            cfg_ready <= 1'b1;
          end
        end

        CLEAR: begin
          if (remaining != '0) begin
            op_ready <= 1'b1;
            state    <= RUN;
          end else begin
            wait_cnt <= WAIT_W'(MAC_LAT);
            state    <= DRAIN;
          end
        end

        RUN: begin
          if (op_hs) begin
            mac_a     <= op_a;
            mac_w     <= op_w;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              op_ready <= 1'b0;
              wait_cnt <= WAIT_W'(MAC_LAT);
              state    <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // The last pair needs MAC_LAT cycles to reach mac_z; capture once
          // the counter has run out.
          if (wait_cnt == '0) begin
            res_z     <= mac_z;
            res_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        OUT: begin
          if (res_hs) begin
            res_valid <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
